// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit per clock, start/done handshake.
// Supports logical (zero-fill) and arithmetic (sign-fill) right shifts.
// The result and last shifted-out bit are registered on completion and
// held until the next completion.
//
// Optional build macro: SHR_EARLY_EXIT_EN
//   When defined, a shift finishes early once the working register holds
//   nothing but fill bits, since further steps cannot change it. Results
//   are identical with or without the macro; only latency differs.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   Start  - request, sampled only while idle
//   A      - operand, captured on accepted Start
//   Shift  - shift amount, captured on accepted Start
//   Arith  - 0 = logical, 1 = arithmetic, captured on accepted Start
//   Busy   - high while a request is being processed (through Done cycle)
//   Done   - one-cycle completion pulse
//   ASR    - registered result
//   Cout   - registered last bit shifted out
module shift_right_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] Shift,
    input  logic             Arith,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ASR,
    output logic             Cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [CNT_W-1:0] cnt;
    logic             f;
    logic [WIDTH-1:0] r_shift;

    // One-step shift of the working register with the captured fill bit
    assign r_shift = {f, r[WIDTH-1:1]};

`ifdef SHR_EARLY_EXIT_EN
    // Register holds only fill bits: remaining steps are no-ops
    logic saturated;
    assign saturated = (r == {WIDTH{f}});
`endif

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            r     <= '0;
            cnt   <= '0;
            f     <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            ASR   <= '0;
            Cout  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        r    <= A;
                        cnt  <= Shift;
                        f    <= Arith & A[WIDTH-1];
                        Busy <= 1'b1;
                        if (Shift == '0) begin
                            // Zero-length shift completes straight away
                            state <= DONE;
                            Done  <= 1'b1;
                            ASR   <= A;
                            Cout  <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
`ifdef SHR_EARLY_EXIT_EN
                    if (saturated) begin
                        state <= DONE;
                        Done  <= 1'b1;
                        ASR   <= r;
                        Cout  <= f;
                    end else begin
`else
                    begin
`endif
                        r   <= r_shift;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            ASR   <= r_shift;
                            Cout  <= r[0];
                        end
                    end
                end

                DONE: begin
                    // Start is ignored here; next accept is from IDLE
                    state <= IDLE;
                    Busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed vector table,
// randomized operations against an arithmetic reference model, and a
// reset-abort sequence.
module tb_shift_right_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] A = 8'h00;
    logic [3:0] Shift = 4'h0;
    logic       Arith = 1'b0;
    logic       Busy;
    logic       Done;
    logic [7:0] ASR;
    logic       Cout;

    int checks = 0;
    int errors = 0;

    shift_right_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .A    (A),
        .Shift(Shift),
        .Arith(Arith),
        .Busy (Busy),
        .Done (Done),
        .ASR  (ASR),
        .Cout (Cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] sh;
        logic       ar;
        logic [7:0] exp_asr;
        logic       exp_cout;
        int         lat_off;
        int         lat_on;
    } vec_t;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Reference: result as fill-extended value shifted by plain arithmetic
    function automatic void model(input logic [7:0] a, input logic [3:0] sh, input logic ar,
                                  output logic [7:0] res, output logic co, output int lat);
        logic        fb;
        logic [15:0] ext;
        logic [7:0]  allf;
        int          m;
        int          n;
        fb   = ar & a[7];
        ext  = {{8{fb}}, a};
        allf = {8{fb}};
        n    = int'(sh);
        res  = (n >= 8) ? allf : 8'(ext >> n);
        if (n == 0)     co = 1'b0;
        else if (n <= 8) co = a[n-1];
        else            co = fb;
`ifdef SHR_EARLY_EXIT_EN
        m = 8;
        for (int j = 8; j >= 0; j--) begin
            if (8'(ext >> j) == allf) m = j;
        end
        lat = (m < n) ? m + 1 : n;
`else
        m   = 0;
        lat = n + m;
`endif
    endfunction

    // Issue one request and observe it to completion
    task automatic do_op(input logic [7:0] a, input logic [3:0] sh, input logic ar,
                         input bit noise,
                         output logic [7:0] asr, output logic cout,
                         output int lat, output int busy_cyc, output bit held,
                         output bit idle_after);
        logic [7:0] prev_asr;
        logic       prev_cout;
        prev_asr  = ASR;
        prev_cout = Cout;
        @(negedge clk);
        Start = 1'b1; A = a; Shift = sh; Arith = ar;
        @(posedge clk); #1;
        lat = -1; busy_cyc = 0; held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (Busy) busy_cyc++;
            if (Done) begin
                lat = i;
                break;
            end
            if (ASR !== prev_asr || Cout !== prev_cout) held = 1'b0;
            @(negedge clk);
            Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            A     = 8'($urandom);
            Shift = 4'($urandom);
            Arith = 1'($urandom);
            @(posedge clk); #1;
        end
        asr  = ASR;
        cout = Cout;
        // Start during the Done cycle must be ignored
        @(negedge clk);
        Start = noise;
        A     = 8'($urandom);
        Shift = 4'($urandom_range(1, 15));
        @(posedge clk); #1;
        idle_after = !Busy && !Done;
        @(negedge clk);
        Start = 1'b0;
    endtask

    vec_t       vecs[10];
    logic [7:0] r_asr;
    logic       r_cout;
    int         r_lat;
    int         r_busy;
    bit         r_held;
    bit         r_idle;
    logic [7:0] m_asr;
    logic       m_cout;
    int         m_lat;
    int         exp_lat;
    int         done_cnt;
    int         busy_cnt;

    initial begin
        vecs[0] = '{8'h96, 4'd3,  1'b0, 8'h12, 1'b1, 3,  3};
        vecs[1] = '{8'h96, 4'd3,  1'b1, 8'hF2, 1'b1, 3,  3};
        vecs[2] = '{8'h5A, 4'd0,  1'b0, 8'h5A, 1'b0, 0,  0};
        vecs[3] = '{8'h5A, 4'd0,  1'b1, 8'h5A, 1'b0, 0,  0};
        vecs[4] = '{8'h80, 4'd15, 1'b1, 8'hFF, 1'b1, 15, 8};
        vecs[5] = '{8'h80, 4'd15, 1'b0, 8'h00, 1'b0, 15, 9};
        vecs[6] = '{8'h01, 4'd1,  1'b0, 8'h00, 1'b1, 1,  1};
        vecs[7] = '{8'hFF, 4'd8,  1'b1, 8'hFF, 1'b1, 8,  1};
        vecs[8] = '{8'h00, 4'd5,  1'b0, 8'h00, 1'b0, 5,  1};
        vecs[9] = '{8'hC3, 4'd7,  1'b1, 8'hFF, 1'b1, 7,  7};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_asr",  32'(ASR),  32'd0);
        chk("reset_cout", 32'(Cout), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        for (int v = 0; v < 10; v++) begin
`ifdef SHR_EARLY_EXIT_EN
            exp_lat = vecs[v].lat_on;
`else
            exp_lat = vecs[v].lat_off;
`endif
            do_op(vecs[v].a, vecs[v].sh, vecs[v].ar, (v % 2) == 1,
                  r_asr, r_cout, r_lat, r_busy, r_held, r_idle);
            chk($sformatf("vec%0d_asr", v),  32'(r_asr),  32'(vecs[v].exp_asr));
            chk($sformatf("vec%0d_cout", v), 32'(r_cout), 32'(vecs[v].exp_cout));
            chk($sformatf("vec%0d_lat", v),  32'(r_lat),  32'(exp_lat));
            chk($sformatf("vec%0d_busy", v), 32'(r_busy), 32'(exp_lat + 1));
            chk($sformatf("vec%0d_hold", v), 32'(r_held), 32'd1);
            chk($sformatf("vec%0d_idle", v), 32'(r_idle), 32'd1);
        end

        // Randomized operations with busy-time noise on Start
        for (int t = 0; t < 60; t++) begin
            logic [7:0] ra;
            logic [3:0] rs;
            logic       rr;
            ra = 8'($urandom);
            rs = 4'($urandom);
            rr = 1'($urandom);
            model(ra, rs, rr, m_asr, m_cout, m_lat);
            do_op(ra, rs, rr, 1'b1, r_asr, r_cout, r_lat, r_busy, r_held, r_idle);
            chk($sformatf("rnd%0d_asr a=%0h s=%0d ar=%0b", t, ra, rs, rr), 32'(r_asr), 32'(m_asr));
            chk($sformatf("rnd%0d_cout", t), 32'(r_cout), 32'(m_cout));
            chk($sformatf("rnd%0d_lat", t),  32'(r_lat),  32'(m_lat));
            chk($sformatf("rnd%0d_hold", t), 32'(r_held), 32'd1);
        end

        // Leave a nonzero result so the reset clear below is observable
        do_op(8'h5A, 4'd0, 1'b0, 1'b0, r_asr, r_cout, r_lat, r_busy, r_held, r_idle);
        chk("pre_abort_asr", 32'(r_asr), 32'h5A);

        // Reset during a 5-step shift with an ignored second Start
        @(negedge clk);
        Start = 1'b1; A = 8'h33; Shift = 4'd5; Arith = 1'b0;
        @(posedge clk);                       // edge k: accepted
        @(negedge clk);
        Start = 1'b0;
        @(posedge clk);                       // edge k+1
        @(negedge clk);
        Start = 1'b1; A = 8'hF0; Shift = 4'd2; Arith = 1'b1;
        @(posedge clk); #1;                   // edge k+2: ignored
        chk("abort_busy_before", 32'(Busy), 32'd1);
        @(negedge clk);
        Start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;                   // edge k+3: reset
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_asr",  32'(ASR),  32'd0);
        chk("abort_cout", 32'(Cout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_busy", 32'(busy_cnt), 32'd0);
        chk("abort_asr_hold", 32'(ASR), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Iterative 8-bit right shifter. Shifts one bit per clock cycle and uses a start/done handshake.
- Complements the ALU's combinational left shifter. It provides both logical (zero-fill) and arithmetic (sign-fill) right shifts.
- The ALU top instantiates it and holds its operands stable only at start. The result is registered and held until the next completion.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 4, width of the shift-amount input (0..2^CNT_W-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- A  input  WIDTH  operand, captured on accepted Start.
- Shift  input  CNT_W  shift amount, captured on accepted Start.
- Arith  input  1  0=logical (fill 0), 1=arithmetic (fill A[WIDTH-1]), captured on accepted Start.
- Busy  output  1  high while state is not IDLE.
- Done  output  1  one-cycle completion pulse.
- ASR  output  WIDTH  registered result.
- Cout  output  1  registered last bit shifted out.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset: state=IDLE; Busy=0, Done=0, ASR=0, Cout=0; internal shift register and counter cleared.
- Reset mid-operation aborts the shift. Results of the aborted shift never appear. Reset has priority over all other events.
- State machine: IDLE, SHIFT, DONE.
- IDLE, Start=1 at edge k: load R=A, cnt=Shift, fill bit F=Arith&A[WIDTH-1], internal carry C=0.
  - Next state is SHIFT if Shift!=0, else DONE.
- SHIFT: each edge does R={F,R[WIDTH-1:1]}, C=R[0], cnt=cnt-1.
  - When cnt==1 at the edge, next state is DONE.
- DONE: Done=1 for exactly this cycle; ASR=R and Cout=C, registered on entry to DONE.
  - Next edge returns to IDLE.
- Latency: for Shift=N, Done is high in the cycle after edge k+N (N=0: the cycle after edge k).
  - Busy is high from edge k through the Done cycle.
  - The earliest next accept is the edge ending the Done cycle? No: Start is ignored in DONE. The next Start is accepted in the cycle after Done.
- Start while Busy=1 is ignored entirely. Captured operands and timing are unaffected.
- Shift >= WIDTH: the shift proceeds to the full count.
  - Logical result is 0; arithmetic result is all-F.
  - Cout is the bit shifted out on the final step: 0 for logical; F for arithmetic once the register is saturated.
- Shift=0: ASR=A, Cout=0.
- ASR and Cout hold their value between completions, including while a new shift is in progress.
- The A, Shift and Arith inputs may change freely after the accept edge.

Optional Feature:
- Macro SHR_EARLY_EXIT_EN.
- Defined: in SHIFT, if at the start of a cycle R equals the all-F pattern and cnt>0, the next edge goes to DONE with R unchanged and C=F. Further shifts could not change the result. Latency becomes data-dependent but never exceeds N.
- Undefined: no detection logic. Latency is always exactly N as specified above.
- Results (ASR, Cout) are identical in both builds for every input.

Test Plan:
- Reset, then A=0x96, Shift=3, Arith=0, Start at edge k -> Done in the cycle after edge k+3; ASR=0x12, Cout=1; Busy high for 4 cycles.
- A=0x96, Shift=3, Arith=1 -> ASR=0xF2, Cout=1, same latency.
- A=0x5A, Shift=0 -> Done in the cycle after edge k; ASR=0x5A, Cout=0.
- A=0x80, Shift=15, Arith=1 -> ASR=0xFF, Cout=1. Done after edge k+15 (macro off) or after edge k+8 (macro on).
- A=0x80, Shift=15, Arith=0 -> ASR=0x00, Cout=0. Done after edge k+15 (off) or k+9 (on).
- Start a 5-step shift, assert Start with new operands at k+2, then reset at k+3 -> second Start ignored. After reset: Busy=0, Done=0, ASR=0, Cout=0, and no Done pulse follows.
